// File: rtl/muldiv_if.sv
// muldiv_if: operand/handshake bundle between issue logic and muldiv.
// master drives requests and mthi/mtlo writes; slave returns status and HI/LO.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, we_hi, we_lo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative 32x32 multiply / divide with architectural HI/LO.
// Divide hardware is present only when MULDIV_DIV_EN is defined.
module muldiv (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [63:0] p;
    logic [31:0] opnd;
    logic        neg;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;

    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        noop;
    logic [32:0] msum;
    logic [63:0] p_mul;
    logic [63:0] p_nx;
    logic [63:0] prod;

    assign sgn   = ~bus.op[0];
    assign a_mag = (sgn && bus.a[31]) ? 32'd0 - bus.a : bus.a;
    assign b_mag = (sgn && bus.b[31]) ? 32'd0 - bus.b : bus.b;

    assign msum  = {1'b0, p[63:32]} + {1'b0, (p[0] ? opnd : 32'd0)};
    assign p_mul = {msum, p[31:1]};
    assign prod  = neg ? 64'd0 - p : p;

`ifdef MULDIV_DIV_EN
    logic        isdiv;
    logic        neg_r;
    logic [32:0] t;
    logic [33:0] diff;
    logic [63:0] p_div;
    logic [31:0] quot;
    logic [31:0] rem;

    assign noop  = 1'b0;
    assign t     = {p[63:32], p[31]};
    assign diff  = {1'b0, t} - {2'b00, opnd};
    assign p_div = diff[33] ? {t[31:0], p[30:0], 1'b0}
                            : {diff[31:0], p[30:0], 1'b1};
    assign p_nx  = isdiv ? p_div : p_mul;
    assign quot  = neg ? 32'd0 - p[31:0] : p[31:0];
    assign rem   = neg_r ? 32'd0 - p[63:32] : p[63:32];
`else
    assign noop  = bus.op[1];
    assign p_nx  = p_mul;
`endif

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // next-state: run 32 iterations, one finishing cycle, back to idle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start && !noop) state_nx = RUN;
            RUN:     if (cnt == 5'd31) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, datapath, HI/LO and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            p      <= 64'd0;
            opnd   <= 32'd0;
            neg    <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            done_r <= 1'b0;
`ifdef MULDIV_DIV_EN
            isdiv  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.we_hi) hi_r <= bus.wd;
                    if (bus.we_lo) lo_r <= bus.wd;
                    if (bus.start) begin
                        if (noop) begin
                            done_r <= 1'b1;
                        end else begin
                            cnt <= 5'd0;
                            neg <= sgn & (bus.a[31] ^ bus.b[31]);
`ifdef MULDIV_DIV_EN
                            isdiv <= bus.op[1];
                            neg_r <= sgn & bus.a[31];
                            if (bus.op[1]) begin
                                p    <= {32'd0, a_mag};
                                opnd <= b_mag;
                            end else begin
                                p    <= {32'd0, b_mag};
                                opnd <= a_mag;
                            end
`else
                            p    <= {32'd0, b_mag};
                            opnd <= a_mag;
`endif
                        end
                    end
                end
                RUN: begin
                    p   <= p_nx;
                    cnt <= cnt + 5'd1;
                end
                FIN: begin
                    done_r <= 1'b1;
                    cnt    <= 5'd0;
`ifdef MULDIV_DIV_EN
                    if (isdiv) begin
                        lo_r <= quot;
                        hi_r <= rem;
                    end else begin
                        {hi_r, lo_r} <= prod;
                    end
`else
                    {hi_r, lo_r} <= prod;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
